// File: rtl/strait_pkg.sv
// Types and default widths shared by the BIST controller, the response analyzer and its fail log.
package strait_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned ADDR_W_DEF    = 4;
  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned LOG_DEPTH_DEF = 4;
  localparam int unsigned CNT_W_DEF     = 8;
endpackage

// File: rtl/strait_fail_fifo.sv
// First-word-fall-through fail log; a pop frees a slot in the same cycle, so a push into a full FIFO alongside a pop is accepted.
// Zero-latency head read; pushes into a full FIFO without a pop are refused (caller flags overflow).
module strait_fail_fifo #(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   occ_q, occ_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign empty    = (occ_q == '0);
  assign full     = (occ_q == (PW+1)'(DEPTH));
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop);
  assign head_dat = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      occ_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + PW'(1);
      if (pop_ok)  rd_d = rd_q + PW'(1);
      occ_d = occ_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  // Storage needs no reset: nothing is visible until occupancy says so.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem_q[wr_q] <= push_dat;
  end
endmodule

// File: rtl/strait_response_analyzer.sv
// Compares BIST reads, counts mismatches, logs failing address/syndrome; done after end-of-test drains.
// Two-stage: sample registered in S1, results update one edge later; log_pop drains the fail log.
module strait_response_analyzer
  import strait_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned LOG_DEPTH = LOG_DEPTH_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cmp_valid,
  input  logic [ADDR_W-1:0] cmp_addr,
  input  logic [DATA_W-1:0] cmp_exp,
  input  logic [DATA_W-1:0] cmp_act,
  input  logic              test_end,
  output logic              fail_flag,
  output logic [CNT_W-1:0]  fail_count,
  output logic              log_valid,
  output logic [ADDR_W-1:0] log_addr,
  output logic [DATA_W-1:0] log_syn,
  input  logic              log_pop,
  output logic              overflow,
  output logic              done
);
  state_e              state_q;
  logic                done_q;
  logic                s1_vld_q, s1_vld_d;
  logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
  logic [DATA_W-1:0]   s1_syn_q, s1_syn_d;
  logic [CNT_W-1:0]    fail_count_q, fail_count_d;
  logic                fail_flag_q, fail_flag_d;
  logic                overflow_q, overflow_d;
  logic                mis, fifo_full, fifo_empty;
  logic [ADDR_W+DATA_W-1:0] head;

  // start discards both the incoming sample and whatever S1 holds.
  assign mis = s1_vld_q && (s1_syn_q != '0) && !start;

  always_comb begin
    s1_vld_d     = cmp_valid && (state_q == RUN) && !start;
    s1_addr_d    = start ? '0 : cmp_addr;
    s1_syn_d     = start ? '0 : (cmp_exp ^ cmp_act);
    fail_count_d = fail_count_q;
    fail_flag_d  = fail_flag_q;
    overflow_d   = overflow_q;
    if (start) begin
      fail_count_d = '0;
      fail_flag_d  = 1'b0;
      overflow_d   = 1'b0;
    end else if (mis) begin
      if (fail_count_q != '1) fail_count_d = fail_count_q + CNT_W'(1);
      fail_flag_d = 1'b1;
      if (fifo_full && !log_pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld_q     <= 1'b0;
      s1_addr_q    <= '0;
      s1_syn_q     <= '0;
      fail_count_q <= '0;
      fail_flag_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_addr_q    <= s1_addr_d;
      s1_syn_q     <= s1_syn_d;
      fail_count_q <= fail_count_d;
      fail_flag_q  <= fail_flag_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else if (start) begin
      state_q <= RUN;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN:     if (test_end) state_q <= FLUSH;
        FLUSH: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  strait_fail_fifo #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clr      (start),
    .push     (mis),
    .push_dat ({s1_addr_q, s1_syn_q}),
    .pop      (log_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head)
  );

  assign fail_flag  = fail_flag_q;
  assign fail_count = fail_count_q;
  assign overflow   = overflow_q;
  assign done       = done_q;
  assign log_valid  = !fifo_empty;
  assign log_addr   = fifo_empty ? '0 : head[DATA_W +: ADDR_W];
  assign log_syn    = fifo_empty ? '0 : head[DATA_W-1:0];
endmodule

// File: tb/tb_strait_response_analyzer.sv
// Directed bench for strait_response_analyzer: vector table plus multi-cycle corner sequences.
module tb_strait_response_analyzer;
  logic       clk = 1'b0;
  logic       reset, start, cmp_valid, test_end, log_pop;
  logic [3:0] cmp_addr;
  logic [7:0] cmp_exp, cmp_act;
  logic       fail_flag, log_valid, overflow, done;
  logic [7:0] fail_count;
  logic [3:0] log_addr;
  logic [7:0] log_syn;
  logic       fail_flag2, log_valid2, overflow2, done2;
  logic [1:0] fail_count2;
  logic [3:0] log_addr2;
  logic [7:0] log_syn2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  strait_response_analyzer #(.ADDR_W(4), .DATA_W(8), .LOG_DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .cmp_valid(cmp_valid), .cmp_addr(cmp_addr),
    .cmp_exp(cmp_exp), .cmp_act(cmp_act), .test_end(test_end), .fail_flag(fail_flag),
    .fail_count(fail_count), .log_valid(log_valid), .log_addr(log_addr), .log_syn(log_syn),
    .log_pop(log_pop), .overflow(overflow), .done(done));

  strait_response_analyzer #(.ADDR_W(4), .DATA_W(8), .LOG_DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .cmp_valid(cmp_valid), .cmp_addr(cmp_addr),
    .cmp_exp(cmp_exp), .cmp_act(cmp_act), .test_end(test_end), .fail_flag(fail_flag2),
    .fail_count(fail_count2), .log_valid(log_valid2), .log_addr(log_addr2), .log_syn(log_syn2),
    .log_pop(log_pop), .overflow(overflow2), .done(done2));

  typedef struct {
    bit       st, v, pop;
    bit [3:0] a;
    bit [7:0] e, x;
    int       c;
    bit       f, lv, ov;
    bit [3:0] la;
    bit [7:0] ls;
  } vec_t;

  vec_t vt[28];

  function automatic vec_t mk(bit st, bit v, bit [3:0] a, bit [7:0] e, bit [7:0] x, bit pop,
                              int c, bit f, bit lv, bit [3:0] la, bit [7:0] ls, bit ov);
    vec_t r;
    r.st = st; r.v = v; r.a = a; r.e = e; r.x = x; r.pop = pop;
    r.c = c; r.f = f; r.lv = lv; r.la = la; r.ls = ls; r.ov = ov;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    start = 0; cmp_valid = 0; test_end = 0; log_pop = 0;
    cmp_addr = 0; cmp_exp = 0; cmp_act = 0;
  endtask

  task automatic sample(input bit [3:0] a, input bit [7:0] e, input bit [7:0] x);
    cmp_valid = 1; cmp_addr = a; cmp_exp = e; cmp_act = x;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_count"}, fail_count, 0);
    chk({nm, "_flag"}, fail_flag, 0);
    chk({nm, "_lv"}, log_valid, 0);
    chk({nm, "_ov"}, overflow, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_laddr"}, log_addr, 0);
    chk({nm, "_lsyn"}, log_syn, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t want below 200000", $time);
    $fatal(1);
  end

  initial begin
    vt[0]  = mk(1,0,4'h0,8'h00,8'h00,0, 0,0,0,4'h0,8'h00,0);
    vt[1]  = mk(0,1,4'h6,8'hFF,8'hFB,0, 0,0,0,4'h0,8'h00,0);
    vt[2]  = mk(0,0,4'h0,8'h00,8'h00,0, 1,1,1,4'h6,8'h04,0);
    vt[3]  = mk(0,0,4'h0,8'h00,8'h00,1, 1,1,0,4'h0,8'h00,0);
    vt[4]  = mk(1,0,4'h0,8'h00,8'h00,0, 0,0,0,4'h0,8'h00,0);
    vt[5]  = mk(0,1,4'h0,8'h00,8'h01,0, 0,0,0,4'h0,8'h00,0);
    vt[6]  = mk(0,1,4'h1,8'h00,8'h02,0, 1,1,1,4'h0,8'h01,0);
    vt[7]  = mk(0,1,4'h2,8'h00,8'h04,0, 2,1,1,4'h0,8'h01,0);
    vt[8]  = mk(0,1,4'h3,8'h00,8'h08,0, 3,1,1,4'h0,8'h01,0);
    vt[9]  = mk(0,1,4'h4,8'h00,8'h10,0, 4,1,1,4'h0,8'h01,0);
    vt[10] = mk(0,1,4'h5,8'h00,8'h20,0, 5,1,1,4'h0,8'h01,1);
    vt[11] = mk(0,0,4'h0,8'h00,8'h00,0, 6,1,1,4'h0,8'h01,1);
    vt[12] = mk(0,0,4'h0,8'h00,8'h00,1, 6,1,1,4'h1,8'h02,1);
    vt[13] = mk(0,0,4'h0,8'h00,8'h00,1, 6,1,1,4'h2,8'h04,1);
    vt[14] = mk(0,0,4'h0,8'h00,8'h00,1, 6,1,1,4'h3,8'h08,1);
    vt[15] = mk(0,0,4'h0,8'h00,8'h00,1, 6,1,0,4'h0,8'h00,1);
    vt[16] = mk(0,0,4'h0,8'h00,8'h00,1, 6,1,0,4'h0,8'h00,1);
    vt[17] = mk(1,0,4'h0,8'h00,8'h00,0, 0,0,0,4'h0,8'h00,0);
    vt[18] = mk(0,1,4'h0,8'h00,8'h01,0, 0,0,0,4'h0,8'h00,0);
    vt[19] = mk(0,1,4'h1,8'h00,8'h02,0, 1,1,1,4'h0,8'h01,0);
    vt[20] = mk(0,1,4'h2,8'h00,8'h03,0, 2,1,1,4'h0,8'h01,0);
    vt[21] = mk(0,1,4'h3,8'h00,8'h04,0, 3,1,1,4'h0,8'h01,0);
    vt[22] = mk(0,1,4'h9,8'h00,8'h09,0, 4,1,1,4'h0,8'h01,0);
    vt[23] = mk(0,0,4'h0,8'h00,8'h00,1, 5,1,1,4'h1,8'h02,0);
    vt[24] = mk(0,0,4'h0,8'h00,8'h00,1, 5,1,1,4'h2,8'h03,0);
    vt[25] = mk(0,0,4'h0,8'h00,8'h00,1, 5,1,1,4'h3,8'h04,0);
    vt[26] = mk(0,0,4'h0,8'h00,8'h00,1, 5,1,1,4'h9,8'h09,0);
    vt[27] = mk(0,0,4'h0,8'h00,8'h00,1, 5,1,0,4'h0,8'h00,0);

    idle_in();
    reset = 0;
    tick(); tick();
    chk_zero("reset");

    // test_end while idle must not complete anything
    reset = 1;
    test_end = 1; tick();
    test_end = 0; tick(); tick();
    chk("idle_test_end_done", done, 0);

    // clean run
    start = 1; tick(); start = 0;
    for (int i = 0; i < 16; i++) begin
      sample(4'(i), 8'h55, 8'h55);
      tick();
    end
    idle_in(); test_end = 1; tick();
    test_end = 0;
    chk("clean_done_early", done, 0);
    tick();
    chk("clean_done", done, 1);
    chk("clean_count", fail_count, 0);
    chk("clean_flag", fail_flag, 0);
    chk("clean_lv", log_valid, 0);
    chk("clean_ov", overflow, 0);

    // samples in DONE are ignored
    sample(4'h2, 8'h00, 8'hFF); tick();
    idle_in(); tick(); tick();
    chk("done_ignore_count", fail_count, 0);
    chk("done_ignore_lv", log_valid, 0);
    chk("done_hold", done, 1);

    for (int i = 0; i < 28; i++) begin
      start = vt[i].st; log_pop = vt[i].pop;
      cmp_valid = vt[i].v; cmp_addr = vt[i].a; cmp_exp = vt[i].e; cmp_act = vt[i].x;
      tick();
      chk($sformatf("v%0d_count", i), fail_count, vt[i].c);
      chk($sformatf("v%0d_count2", i), fail_count2, (vt[i].c > 3) ? 3 : vt[i].c);
      chk($sformatf("v%0d_flag", i), fail_flag, vt[i].f);
      chk($sformatf("v%0d_lv", i), log_valid, vt[i].lv);
      chk($sformatf("v%0d_laddr", i), log_addr, vt[i].la);
      chk($sformatf("v%0d_lsyn", i), log_syn, vt[i].ls);
      chk($sformatf("v%0d_ov", i), overflow, vt[i].ov);
    end
    idle_in();

    // mismatch coincident with test_end is counted before done
    start = 1; tick(); start = 0;
    sample(4'h7, 8'h00, 8'h80); test_end = 1; tick();
    idle_in();
    chk("te_mis_done_early", done, 0);
    tick();
    chk("te_mis_done", done, 1);
    chk("te_mis_count", fail_count, 1);
    chk("te_mis_flag", fail_flag, 1);
    chk("te_mis_laddr", log_addr, 7);
    chk("te_mis_lsyn", log_syn, 8'h80);

    // start while in DONE clears everything
    start = 1; tick(); start = 0;
    chk_zero("start_in_done");

    // asynchronous reset mid-run with two logged faults
    sample(4'h1, 8'h0F, 8'h0E); tick();
    sample(4'h2, 8'hF0, 8'h70); tick();
    idle_in(); tick();
    chk("prereset_count", fail_count, 2);
    chk("prereset_lsyn", log_syn, 8'h01);
    #2 reset = 0;
    #1 chk_zero("async_reset");
    tick();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      sample(4'(i), 8'h00, 8'h11); tick();
    end
    idle_in(); tick(); tick();
    chk("post_reset_count", fail_count, 0);
    chk("post_reset_lv", log_valid, 0);
    chk("post_reset_flag", fail_flag, 0);

    // start wins over test_end in the same cycle
    start = 1; test_end = 1; tick();
    idle_in();
    sample(4'h3, 8'h00, 8'h01); tick();
    idle_in(); tick();
    chk("start_te_count", fail_count, 1);
    chk("start_te_done", done, 0);
    test_end = 1; tick(); test_end = 0; tick();
    chk("start_te_final_done", done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/strait_response_analyzer.md
Name: strait_response_analyzer

Overview:
- Output response analyzer directly downstream of the STRAIT BIST controller/memory read path.
- Takes each BIST read (address, expected data, actual data), compares them, keeps a saturating fail count and a sticky fail flag, and logs failing addresses with XOR syndromes in a small FIFO.
- Raises done once the controller signals end-of-test and the compare pipeline has drained; the top-level done is derived from it.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 8, memory data width.
- LOG_DEPTH, 4, fail-log FIFO entries; power of two, ≥2.
- CNT_W, 8, fail counter width; saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; clears all results and arms the analyzer.
- cmp_valid  input  1  one read sample presented this cycle.
- cmp_addr  input  ADDR_W  address of the sample.
- cmp_exp  input  DATA_W  expected data.
- cmp_act  input  DATA_W  data read from memory.
- test_end  input  1  one-cycle pulse; controller has issued its last read.
- fail_flag  output  1  sticky: at least one mismatch since start.
- fail_count  output  CNT_W  number of mismatches, saturating.
- log_valid  output  1  FIFO non-empty; head entry is on log_addr/log_syn.
- log_addr  output  ADDR_W  head entry address.
- log_syn  output  DATA_W  head entry syndrome (exp XOR act).
- log_pop  input  1  consume head entry when log_valid=1; ignored when empty.
- overflow  output  1  sticky: a mismatch was dropped because the FIFO was full.
- done  output  1  level; analysis complete; held until the next start.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (any time, including mid-test) forces state IDLE, clears the stage-1 register, zeroes the FIFO pointers and occupancy, and drives all outputs to 0.
- Stage 1 (S1): on each clock in RUN, register cmp_valid, cmp_addr and syn = cmp_exp ^ cmp_act. S1 valid = cmp_valid AND state==RUN.
  - Samples presented in IDLE or DONE are ignored.
- Stage 2: if S1 valid and syn != 0:
  - fail_count increments unless saturated.
  - fail_flag is set.
  - The entry is pushed if the FIFO is not full; otherwise overflow is set and the entry is dropped.
  - Counting happens even when the entry is dropped.
- Latency: a sample accepted at edge N is reflected in fail_count, fail_flag and log_valid after edge N+1.
- FIFO:
  - First-word-fall-through.
  - Pointers are log2(LOG_DEPTH) bits and wrap modulo LOG_DEPTH.
  - Occupancy counter is log2(LOG_DEPTH)+1 bits.
  - Push and pop in the same cycle: if not empty, both occur and occupancy is unchanged. If full, the pop frees the slot and the push is accepted with no overflow. If empty, only the push occurs.
  - The FIFO may be read at any time; it is not cleared by done, only by start or reset.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on start.
  - RUN -> FLUSH on test_end. A cmp_valid in the same cycle as test_end is still accepted.
  - FLUSH -> DONE after exactly one cycle, letting the last S1 sample retire.
  - DONE: done=1, holds until start.
- start in any state:
  - Synchronously clears fail_count, fail_flag, overflow, the FIFO and S1.
  - Goes to RUN; done drops on the next edge.
  - start takes priority over test_end and over a sample in the same cycle; that sample is discarded.
- test_end outside RUN is ignored.
- All outputs are registered except log_addr/log_syn, which are the FIFO read mux of a registered array.

Decomposition:
- Shared package strait_pkg holds:
  - The state enum localparams (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2, DONE=2'd3).
  - Default widths shared with the BIST controller and top.
- One natural sub-module: strait_fail_fifo, a parameterised FWFT FIFO with push/pop/full/empty and an occupancy count. The analyzer instantiates it once.

Test Plan:
- Clean run: reset low for 2 cycles, start, 16 samples with exp==act (addr 0..15, data 8'h55), test_end -> done high 2 cycles after test_end; fail_count=0, fail_flag=0, log_valid=0, overflow=0.
- Single fault: sample addr 4'h6 with exp=8'hFF, act=8'hFB -> one cycle later fail_count=1, fail_flag=1, log_valid=1, log_addr=6, log_syn=8'h04; one log_pop -> log_valid=0.
- Overflow: 6 mismatches at addr 0..5 with no pops -> fail_count=6, FIFO holds addr 0..3 in order, overflow=1. Pop 4 -> addresses 0,1,2,3, then log_valid=0.
- Full with simultaneous push/pop: fill 4 entries, then present a mismatch at addr 9 while asserting log_pop -> overflow stays 0, occupancy stays 4, tail entry is addr 9.
- Boundary: mismatch coincident with test_end is counted before done. With CNT_W=2, 5 mismatches -> fail_count saturates at 3. start asserted in DONE -> all results 0, done=0 next cycle.
- Reset mid-run: reset low while in RUN with 2 logged faults -> all outputs 0 immediately (asynchronous), state IDLE; samples after release are ignored until start.
